// File: rtl/sgp_job_sequencer.sv
// Job controller for the steganography datapath: decodes the PS control word,
// checks embedding capacity, sequences datapath reset/start and reports status.
module sgp_job_sequencer #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned CLR_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [REG_WIDTH-1:0] control_signal,
  input  logic [REG_WIDTH-1:0] picture_size,
  input  logic [REG_WIDTH-1:0] message_size,
  input  logic                 out_finish,
  output logic                 dp_rst_n,
  output logic                 start,
  output logic                 sgp_mode,
  output logic                 out_sel,
  output logic [REG_WIDTH-1:0] pixel_size,
  output logic [REG_WIDTH-1:0] secret_size,
  output logic [REG_WIDTH-1:0] output_size,
  output logic                 ps_enb,
  output logic [REG_WIDTH-1:0] respond_signal
);

  localparam int unsigned CNT_W = REG_WIDTH - 8;
  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 go_prev_q, go_prev_d;
  logic                 abort_prev_q, abort_prev_d;
  logic [REG_WIDTH-1:0] pic_q, pic_d;
  logic [REG_WIDTH-1:0] msg_q, msg_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic                 done_q, done_d;
  logic                 err_size_q, err_size_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_abort_q, err_abort_d;

  logic                 dp_rst_n_q, dp_rst_n_d;
  logic                 start_q, start_d;
  logic                 sgp_mode_q, sgp_mode_d;
  logic                 out_sel_q, out_sel_d;
  logic [REG_WIDTH-1:0] pixel_size_q, pixel_size_d;
  logic [REG_WIDTH-1:0] secret_size_q, secret_size_d;
  logic [REG_WIDTH-1:0] output_size_q, output_size_d;
  logic                 ps_enb_q, ps_enb_d;
  logic [REG_WIDTH-1:0] respond_q, respond_d;

  logic go_edge, abort_edge, mode_in, ack, size_bad, busy;
  logic unused_ctrl_bits;

  assign mode_in          = control_signal[1];
  assign ack              = control_signal[3];
  assign go_edge          = control_signal[0] & ~go_prev_q;
  assign abort_edge       = control_signal[2] & ~abort_prev_q;
  assign unused_ctrl_bits = ^control_signal[REG_WIDTH-1:4];

  // message_size*8 is formed in REG_WIDTH+3 bits so the capacity test never wraps
  assign size_bad = ({msg_q, 3'b000} > {3'b000, pic_q}) || (pic_q == '0) || (msg_q == '0);

  always_comb begin
    state_d        = state_q;
    go_prev_d      = control_signal[0];
    abort_prev_d   = control_signal[2];
    pic_d          = pic_q;
    msg_d          = msg_q;
    clr_cnt_d      = clr_cnt_q;
    wd_cnt_d       = wd_cnt_q;
    cycle_count_d  = cycle_count_q;
    done_d         = done_q;
    err_size_d     = err_size_q;
    err_timeout_d  = err_timeout_q;
    err_abort_d    = err_abort_q;
    sgp_mode_d     = sgp_mode_q;
    out_sel_d      = out_sel_q;
    pixel_size_d   = pixel_size_q;
    secret_size_d  = secret_size_q;
    output_size_d  = output_size_q;

    case (state_q)
      S_IDLE: begin
        if (go_edge) begin
          state_d    = S_CHECK;
          pic_d      = picture_size;
          msg_d      = message_size;
          sgp_mode_d = mode_in;
          out_sel_d  = mode_in;
          if (mode_in) begin
            pixel_size_d  = {message_size[REG_WIDTH-4:0], 3'b000};
            secret_size_d = '0;
            output_size_d = message_size;
          end else begin
            pixel_size_d  = picture_size;
            secret_size_d = message_size;
            output_size_d = picture_size;
          end
        end
      end
      S_CHECK: begin
        if (abort_edge) begin
          state_d     = S_ERROR;
          err_abort_d = 1'b1;
        end else if (size_bad) begin
          state_d    = S_ERROR;
          err_size_d = 1'b1;
        end else begin
          state_d       = S_CLEAR;
          clr_cnt_d     = '0;
          wd_cnt_d      = '0;
          cycle_count_d = '0;
        end
      end
      S_CLEAR: begin
        if (abort_edge) begin
          state_d     = S_ERROR;
          err_abort_d = 1'b1;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      S_RUN: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
        // finish takes priority so a job that completed is never reported as aborted
        if (out_finish) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d       = S_ERROR;
          err_timeout_d = 1'b1;
        end else if (abort_edge) begin
          state_d     = S_ERROR;
          err_abort_d = 1'b1;
        end
      end
      S_DONE, S_ERROR: begin
        if (ack) begin
          state_d       = S_IDLE;
          done_d        = 1'b0;
          err_size_d    = 1'b0;
          err_timeout_d = 1'b0;
          err_abort_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy       = (state_q == S_CHECK) || (state_q == S_CLEAR) || (state_q == S_RUN);
    dp_rst_n_d = (state_q == S_RUN) || (state_q == S_DONE) || (state_q == S_ERROR);
    start_d    = (state_q == S_RUN);
    ps_enb_d   = (state_q != S_RUN);
    respond_d  = {cycle_count_q, state_q, err_abort_q, err_timeout_q, err_size_q, done_q, busy};
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      // edge history tracks the live level so a request held through reset is not a new edge
      go_prev_q     <= control_signal[0];
      abort_prev_q  <= control_signal[2];
      pic_q         <= '0;
      msg_q         <= '0;
      clr_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      err_size_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_abort_q   <= 1'b0;
      dp_rst_n_q    <= 1'b0;
      start_q       <= 1'b0;
      sgp_mode_q    <= 1'b0;
      out_sel_q     <= 1'b0;
      pixel_size_q  <= '0;
      secret_size_q <= '0;
      output_size_q <= '0;
      ps_enb_q      <= 1'b1;
      respond_q     <= '0;
    end else begin
      state_q       <= state_d;
      go_prev_q     <= go_prev_d;
      abort_prev_q  <= abort_prev_d;
      pic_q         <= pic_d;
      msg_q         <= msg_d;
      clr_cnt_q     <= clr_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      err_size_q    <= err_size_d;
      err_timeout_q <= err_timeout_d;
      err_abort_q   <= err_abort_d;
      dp_rst_n_q    <= dp_rst_n_d;
      start_q       <= start_d;
      sgp_mode_q    <= sgp_mode_d;
      out_sel_q     <= out_sel_d;
      pixel_size_q  <= pixel_size_d;
      secret_size_q <= secret_size_d;
      output_size_q <= output_size_d;
      ps_enb_q      <= ps_enb_d;
      respond_q     <= respond_d;
    end
  end

  assign dp_rst_n       = dp_rst_n_q;
  assign start          = start_q;
  assign sgp_mode       = sgp_mode_q;
  assign out_sel        = out_sel_q;
  assign pixel_size     = pixel_size_q;
  assign secret_size    = secret_size_q;
  assign output_size    = output_size_q;
  assign ps_enb         = ps_enb_q;
  assign respond_signal = respond_q;

endmodule

// File: tb/tb_sgp_job_sequencer.sv
// Directed bench for sgp_job_sequencer: a default instance for job flows and a
// short-watchdog instance for the timeout scenario.
module tb_sgp_job_sequencer;

  logic        sys_clk = 1'b0;
  logic        reset, wd_reset;
  logic        go, mode, abort, ack;
  logic [31:0] control_signal;
  logic [31:0] picture_size, message_size;
  logic        out_finish;

  logic        dp_rst_n, start, sgp_mode, out_sel, ps_enb;
  logic [31:0] pixel_size, secret_size, output_size, respond_signal;

  logic        wd_dp_rst_n, wd_start, wd_sgp_mode, wd_out_sel, wd_ps_enb;
  logic [31:0] wd_pixel_size, wd_secret_size, wd_output_size, wd_respond;

  int checks = 0;
  int passes = 0;

  always #5 sys_clk = ~sys_clk;

  // upper control bits carry junk that the design must ignore
  assign control_signal = {28'h5A5A5A5, ack, abort, mode, go};

  sgp_job_sequencer #(.REG_WIDTH(32), .CLR_CYCLES(4), .TIMEOUT_CYCLES(1 << 24)) u_dut (
    .sys_clk(sys_clk), .reset(reset), .control_signal(control_signal),
    .picture_size(picture_size), .message_size(message_size), .out_finish(out_finish),
    .dp_rst_n(dp_rst_n), .start(start), .sgp_mode(sgp_mode), .out_sel(out_sel),
    .pixel_size(pixel_size), .secret_size(secret_size), .output_size(output_size),
    .ps_enb(ps_enb), .respond_signal(respond_signal)
  );

  sgp_job_sequencer #(.REG_WIDTH(32), .CLR_CYCLES(4), .TIMEOUT_CYCLES(50)) u_wd (
    .sys_clk(sys_clk), .reset(wd_reset), .control_signal(control_signal),
    .picture_size(picture_size), .message_size(message_size), .out_finish(out_finish),
    .dp_rst_n(wd_dp_rst_n), .start(wd_start), .sgp_mode(wd_sgp_mode), .out_sel(wd_out_sel),
    .pixel_size(wd_pixel_size), .secret_size(wd_secret_size), .output_size(wd_output_size),
    .ps_enb(wd_ps_enb), .respond_signal(wd_respond)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic wait_start(output int clr_seen);
    clr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start === 1'b1) break;
      if (respond_signal[7:5] === 3'd2 && dp_rst_n === 1'b0) clr_seen++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wd_reset = 1'b1;
    go = 0; mode = 0; abort = 0; ack = 0; out_finish = 0;
    picture_size = 0; message_size = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (respond_signal !== 32'h0) $display("FAIL reset_respond got %h want %h", respond_signal, 32'h0); else passes++;
    checks++; if (dp_rst_n !== 1'b0) $display("FAIL reset_dp_rst_n got %b want 0", dp_rst_n); else passes++;
    checks++; if (start !== 1'b0) $display("FAIL reset_start got %b want 0", start); else passes++;
    checks++; if (ps_enb !== 1'b1) $display("FAIL reset_ps_enb got %b want 1", ps_enb); else passes++;
    checks++; if (pixel_size !== 32'h0) $display("FAIL reset_pixel_size got %h want 0", pixel_size); else passes++;
  endtask

  task automatic test_embed();
    int clr_seen;
    picture_size = 64; message_size = 8; mode = 0;
    pulse_go();
    checks++; if (pixel_size !== 32'd64) $display("FAIL embed_pixel got %0d want 64", pixel_size); else passes++;
    checks++; if (secret_size !== 32'd8) $display("FAIL embed_secret got %0d want 8", secret_size); else passes++;
    checks++; if (output_size !== 32'd64) $display("FAIL embed_output got %0d want 64", output_size); else passes++;
    checks++; if (out_sel !== 1'b0) $display("FAIL embed_out_sel got %b want 0", out_sel); else passes++;
    checks++; if (respond_signal !== 32'h0) $display("FAIL embed_lat1 got %h want %h", respond_signal, 32'h0); else passes++;
    tick();
    checks++; if (respond_signal !== 32'h21) $display("FAIL embed_lat2 got %h want %h", respond_signal, 32'h21); else passes++;
    wait_start(clr_seen);
    checks++; if (start !== 1'b1) $display("FAIL embed_start got %b want 1", start); else passes++;
    checks++; if (clr_seen !== 4) $display("FAIL embed_clear_len got %0d want 4", clr_seen); else passes++;
    checks++; if (ps_enb !== 1'b0) $display("FAIL embed_run_ps_enb got %b want 0", ps_enb); else passes++;
    checks++; if (dp_rst_n !== 1'b1) $display("FAIL embed_run_dp_rst_n got %b want 1", dp_rst_n); else passes++;
    repeat (98) tick();
    out_finish = 1'b1;
    tick();
    out_finish = 1'b0;
    tick();
    checks++; if (respond_signal !== 32'h6482) $display("FAIL embed_done got %h want %h", respond_signal, 32'h6482); else passes++;
    checks++; if (start !== 1'b0) $display("FAIL embed_done_start got %b want 0", start); else passes++;
    checks++; if (ps_enb !== 1'b1) $display("FAIL embed_done_ps_enb got %b want 1", ps_enb); else passes++;
    do_ack();
    checks++; if (respond_signal !== 32'h6400) $display("FAIL embed_ack got %h want %h", respond_signal, 32'h6400); else passes++;
  endtask

  task automatic test_extract();
    int clr_seen;
    picture_size = 1024; message_size = 16; mode = 1;
    pulse_go();
    checks++; if (pixel_size !== 32'd128) $display("FAIL extract_pixel got %0d want 128", pixel_size); else passes++;
    checks++; if (secret_size !== 32'd0) $display("FAIL extract_secret got %0d want 0", secret_size); else passes++;
    checks++; if (output_size !== 32'd16) $display("FAIL extract_output got %0d want 16", output_size); else passes++;
    checks++; if (out_sel !== 1'b1) $display("FAIL extract_out_sel got %b want 1", out_sel); else passes++;
    checks++; if (sgp_mode !== 1'b1) $display("FAIL extract_mode got %b want 1", sgp_mode); else passes++;
    wait_start(clr_seen);
    checks++; if (start !== 1'b1) $display("FAIL extract_start got %b want 1", start); else passes++;
    out_finish = 1'b1;
    tick();
    out_finish = 1'b0;
    tick();
    checks++; if (respond_signal !== 32'h282) $display("FAIL extract_done got %h want %h", respond_signal, 32'h282); else passes++;
    do_ack();
    mode = 0;
  endtask

  task automatic test_capacity();
    int saw_start;
    saw_start = 0;
    picture_size = 63; message_size = 8;
    pulse_go();
    if (start !== 1'b0 || ps_enb !== 1'b1) saw_start++;
    tick();
    if (start !== 1'b0 || ps_enb !== 1'b1) saw_start++;
    tick();
    if (start !== 1'b0 || ps_enb !== 1'b1) saw_start++;
    checks++; if (respond_signal !== 32'h2A4) $display("FAIL cap_small got %h want %h", respond_signal, 32'h2A4); else passes++;
    do_ack();
    picture_size = 64; message_size = 0;
    pulse_go();
    repeat (2) begin
      tick();
      if (start !== 1'b0 || ps_enb !== 1'b1) saw_start++;
    end
    checks++; if (respond_signal !== 32'h2A4) $display("FAIL cap_zero_msg got %h want %h", respond_signal, 32'h2A4); else passes++;
    checks++; if (saw_start !== 0) $display("FAIL cap_start_ps_enb got %0d bad samples want 0", saw_start); else passes++;
    do_ack();
    checks++; if (respond_signal[7:0] !== 8'h00) $display("FAIL cap_ack got %h want %h", respond_signal[7:0], 8'h00); else passes++;
  endtask

  task automatic test_abort();
    int clr_seen;
    picture_size = 64; message_size = 8; mode = 0;
    pulse_go();
    wait_start(clr_seen);
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++; if (respond_signal !== 32'hCB0) $display("FAIL abort_run got %h want %h", respond_signal, 32'hCB0); else passes++;
    checks++; if (start !== 1'b0) $display("FAIL abort_run_start got %b want 0", start); else passes++;
    do_ack();
    pulse_go();
    wait_start(clr_seen);
    abort = 1'b1; out_finish = 1'b1;
    tick();
    abort = 1'b0; out_finish = 1'b0;
    tick();
    checks++; if (respond_signal !== 32'h282) $display("FAIL abort_vs_finish got %h want %h", respond_signal, 32'h282); else passes++;
    do_ack();
    pulse_go();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++; if (respond_signal !== 32'hB0) $display("FAIL abort_clear got %h want %h", respond_signal, 32'hB0); else passes++;
    do_ack();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++; if (respond_signal !== 32'h0) $display("FAIL abort_idle got %h want %h", respond_signal, 32'h0); else passes++;
  endtask

  task automatic test_watchdog();
    int run_len;
    run_len = 0;
    wd_reset = 1'b1;
    tick();
    wd_reset = 1'b0;
    tick();
    picture_size = 64; message_size = 8; mode = 0;
    pulse_go();
    for (int i = 0; i < 20; i++) begin
      if (wd_start === 1'b1) break;
      tick();
    end
    while (wd_start === 1'b1 && run_len < 200) begin
      run_len++;
      tick();
    end
    checks++; if (run_len !== 50) $display("FAIL wd_run_len got %0d want 50", run_len); else passes++;
    checks++; if (wd_respond !== 32'h32A8) $display("FAIL wd_respond got %h want %h", wd_respond, 32'h32A8); else passes++;
    checks++; if (wd_start !== 1'b0) $display("FAIL wd_start got %b want 0", wd_start); else passes++;
    wd_reset = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_edge();
    int clr_seen;
    picture_size = 64; message_size = 8; mode = 1;
    pulse_go();
    wait_start(clr_seen);
    reset = 1'b1; go = 1'b1;
    tick();
    checks++; if (respond_signal !== 32'h0) $display("FAIL rst_run_respond got %h want %h", respond_signal, 32'h0); else passes++;
    checks++; if (start !== 1'b0 || dp_rst_n !== 1'b0 || ps_enb !== 1'b1) $display("FAIL rst_run_ctrl got start=%b dp_rst_n=%b ps_enb=%b want 0 0 1", start, dp_rst_n, ps_enb); else passes++;
    checks++; if (pixel_size !== 32'h0 || sgp_mode !== 1'b0 || out_sel !== 1'b0) $display("FAIL rst_run_latched got pixel=%h mode=%b sel=%b want 0 0 0", pixel_size, sgp_mode, out_sel); else passes++;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (respond_signal !== 32'h0 || pixel_size !== 32'h0) $display("FAIL go_held got respond=%h pixel=%h want 0 0", respond_signal, pixel_size); else passes++;
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    checks++; if (pixel_size !== 32'd64) $display("FAIL go_toggle_pixel got %0d want 64", pixel_size); else passes++;
    tick();
    checks++; if (respond_signal !== 32'h21) $display("FAIL go_toggle_busy got %h want %h", respond_signal, 32'h21); else passes++;
    go = 1'b0;
  endtask

  initial begin
    test_reset();
    test_embed();
    test_extract();
    test_capacity();
    test_abort();
    test_watchdog();
    test_reset_edge();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
